// File: rtl/rotation_scheduler.sv
// Round-robin sequencer in front of the shared rotation engine: accepts one
// angle job from two channels, snapshots the config, runs it with a timeout guard.
module rotation_scheduler #(
    parameter int ANGLE_W = 14,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [ANGLE_W-1:0] req_angle0,
    input  logic [ANGLE_W-1:0] req_angle1,
    input  logic [ANGLE_W-1:0] cfg_r_fixed,
    input  logic [3:0]         cfg_adder,
    input  logic [4:0]         cfg_error,
    output logic               eng_start,
    output logic [ANGLE_W-1:0] eng_angle,
    output logic [ANGLE_W-1:0] eng_r_fixed,
    output logic [3:0]         eng_adder,
    output logic [4:0]         eng_error,
    input  logic               eng_done,
    input  logic [OUT_W-1:0]   eng_cord,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [OUT_W-1:0]   res_cord,
    output logic               res_err,
    output logic               timeout_err,
    output logic               busy
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant_id;
    logic             accept;
    logic             wait_timeout;
    logic [CNT_W-1:0] wait_cnt;

    // Both valid: the channel that did not win last time gets the grant.
    always_comb begin
        grant_id  = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        if (state == IDLE && rst_n && req_valid != 2'b00)
            req_ready = grant_id ? 2'b10 : 2'b01;
    end

    assign accept       = |req_ready;
    assign wait_timeout = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign eng_start    = (state == ISSUE) && rst_n;
    assign res_valid    = (state == RESP);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (eng_done || wait_timeout) state_next = RESP;
            RESP:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A completion on the final wait cycle takes priority over the abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            eng_angle   <= '0;
            eng_r_fixed <= '0;
            eng_adder   <= '0;
            eng_error   <= '0;
            res_id      <= 1'b0;
            res_cord    <= '0;
            res_err     <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (accept) begin
                eng_angle   <= grant_id ? req_angle1 : req_angle0;
                eng_r_fixed <= cfg_r_fixed;
                eng_adder   <= cfg_adder;
                eng_error   <= cfg_error;
                res_id      <= grant_id;
                last_grant  <= grant_id;
            end
            case (state)
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (eng_done) begin
                        res_cord <= eng_cord;
                        res_err  <= 1'b0;
                    end else if (wait_timeout) begin
                        res_cord    <= '0;
                        res_err     <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rotation_scheduler.md
# rotation_scheduler

Sequencer and arbiter in front of the shared multiple-constant-rotation datapath. It takes angle requests from two independent channels, arbitrates round-robin, and snapshots the rotation configuration (radius, adder, error) per job. It issues one job at a time to the rotation engine, waits for completion with a timeout guard, and returns the 8-bit coordinate result tagged with the requesting channel.

## Interface
Parameters:
- ANGLE_W, 14, width of angle and radius words
- OUT_W, 8, width of engine result coordinate
- TIMEOUT, 64, max WAIT cycles before a job is aborted (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  2  per-channel request valid (bit 0 = ch0, bit 1 = ch1)
- req_ready  out  2  per-channel accept; at most one bit high
- req_angle0  in  ANGLE_W  ch0 angle
- req_angle1  in  ANGLE_W  ch1 angle
- cfg_r_fixed  in  ANGLE_W  fixed radius for next job
- cfg_adder  in  4  adder constant for next job
- cfg_error  in  5  error/iteration constant for next job
- eng_start  out  1  one-cycle start pulse to engine
- eng_angle  out  ANGLE_W  latched job angle
- eng_r_fixed  out  ANGLE_W  latched radius
- eng_adder  out  4  latched adder
- eng_error  out  5  latched error
- eng_done  in  1  engine completion pulse
- eng_cord  in  OUT_W  engine result, valid with eng_done
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_id  out  1  channel that issued the job
- res_cord  out  OUT_W  result coordinate
- res_err  out  1  result is a timeout abort
- timeout_err  out  1  sticky: any job has timed out since reset
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready is combinational from req_valid and last_grant. If one valid, grant it; if both are valid, grant the channel ≠ last_grant. On valid&ready: latch angle, all cfg_* inputs, and grant id; update last_grant; go to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; clear wait counter; go to WAIT. An eng_done arriving in ISSUE is ignored.
- WAIT: counter increments every cycle.
  - eng_done=1: latch eng_cord into res_cord, res_err=0; go to RESP.
  - Else, if counter == TIMEOUT-1: res_cord=0, res_err=1, set timeout_err; go to RESP.
  - If eng_done coincides with the timeout cycle, done wins (res_err=0, timeout_err unchanged).
- RESP: res_valid=1; res_id/res_cord/res_err held stable until res_valid&res_ready, then go to IDLE. eng_done pulses in RESP or IDLE are ignored.
- req_ready=0 in all states except IDLE. eng_* data outputs hold the latched job values and change only on acceptance.
- Changes to cfg_* inputs while busy do not affect the in-flight job.
- Reset (any state, including mid-job): state=IDLE; eng_start=0, req_ready=0 on the reset cycle; res_valid=0, res_id=0, res_cord=0, res_err=0, timeout_err=0, eng_angle/eng_r_fixed/eng_adder/eng_error=0, counter=0, last_grant=1 (ch0 wins first contention). An in-flight job is dropped and produces no result.

## Timing
- Accept at cycle T (IDLE); eng_start at T+1; WAIT begins at T+2.
- eng_done seen at WAIT cycle T+1+k (k≥1) → res_valid from T+2+k.
- Minimum accept-to-result latency is 3 cycles; with res_ready held high, the next accept is no earlier than 1 cycle after the result handshake (back-to-back jobs every 4 cycles minimum with a 1-cycle engine).
- Timeout: with no eng_done, res_valid (res_err=1) asserts TIMEOUT+2 cycles after acceptance.
- timeout_err is set in the cycle res_valid first asserts for the aborted job. It clears only on reset.

## Test plan
- Single job: cfg_r_fixed=0x07E0, cfg_adder=8, cfg_error=7; ch0 angle 0x1300; engine returns done 3 cycles after start with eng_cord=0x5A → eng_start one cycle after accept carrying exactly these values; res_valid with res_id=0, res_cord=0x5A, res_err=0.
- Contention: both channels valid from reset (ch0=0x1300, ch1=0x1A00) held continuously → grant order ch0, ch1, ch0, ch1; never both req_ready bits high.
- Timeout: TIMEOUT=8, engine never responds → res_valid at accept+10 with res_err=1, res_cord=0, timeout_err=1 thereafter; next job completes normally with timeout_err still 1.
- Backpressure and config isolation: res_ready=0 for 5 cycles while cfg_adder is changed to 3 → res_* stable, req_ready=0, busy=1; released result matches the original job; next job's eng_adder=3.
- Done on timeout boundary: eng_done pulses exactly in WAIT cycle TIMEOUT-1 → res_err=0, timeout_err stays 0. Stray eng_done during ISSUE is ignored.
- Reset mid-WAIT: assert rst_n=0 for one cycle → next cycle all outputs at reset values, no res_valid for the dropped job; ch0 is granted first afterwards.
